// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// Register file with two access ports sharing one bank of flops.
//   Port A (executor): never stalls. Registered read (one-cycle latency,
//   read-before-write on the same edge) and a write that lands every edge
//   a_we is high.
//   Port B (debug): level request / one-cycle ack handshake driven by a
//   small FSM. A request is only accepted on an edge where port A is not
//   writing, so the two ports never write the bank on the same edge.
//
// Parameters
//   NREGS  number of registers, ids 0..NREGS-1 (ids are 4 bits, so at most 16)
//   WIDTH  register width in bits
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    asynchronous active-high reset
//   a_id   port A register select
//   a_re   port A read enable, a_out loads regs[a_id] at the edge
//   a_we   port A write enable, regs[a_id] loads a_wd at the edge
//   a_wd   port A write data
//   a_out  port A registered read data
//   b_req  port B request level, held until b_ack
//   b_we   port B request type: 1 write, 0 read
//   b_id   port B register select
//   b_wd   port B write data
//   b_ack  port B one-cycle completion pulse (registered)
//   b_rd   port B read data, valid with b_ack and held until the next ack
// ---------------------------------------------------------------------------
module reg_file #(
   parameter int NREGS = 16,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       a_id,
   input  logic             a_re,
   input  logic             a_we,
   input  logic [WIDTH-1:0] a_wd,
   output logic [WIDTH-1:0] a_out,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [3:0]       b_id,
   input  logic [WIDTH-1:0] b_wd,
   output logic             b_ack,
   output logic [WIDTH-1:0] b_rd
);

   // Index width for the storage array. The 4-bit ids are range-checked
   // against NREGS first, so only the low IDX_W bits ever reach the array.
   localparam int         IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [4:0] ID_LIMIT = 5'(NREGS);

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      WAITLOW
   } b_state_t;

   b_state_t         b_state;
   b_state_t         b_state_next;
   logic             b_accept;

   logic [WIDTH-1:0] regs [NREGS];

   logic             a_valid;
   logic             b_valid;
   logic [WIDTH-1:0] a_rdata;
   logic [WIDTH-1:0] b_rdata;

   // Id range checks and the combinational read muxes. An out-of-range id
   // reads as zero, which also keeps the array index in bounds.
   always_comb begin
      a_valid = ({1'b0, a_id} < ID_LIMIT);
      b_valid = ({1'b0, b_id} < ID_LIMIT);
      a_rdata = '0;
      b_rdata = '0;
      if (a_valid) begin
         a_rdata = regs[a_id[IDX_W-1:0]];
      end
      if (b_valid) begin
         b_rdata = regs[b_id[IDX_W-1:0]];
      end
   end

   // Storage. Port A wins outright; port B can only write on an accepting
   // edge, and acceptance already requires a_we low, so the else-branch
   // never hides a real port B write. Writes to out-of-range ids are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (a_we) begin
            if (a_valid) begin
               regs[a_id[IDX_W-1:0]] <= a_wd;
            end
         end else if (b_accept && b_we && b_valid) begin
            regs[b_id[IDX_W-1:0]] <= b_wd;
         end
      end
   end

   // Port A read register. It samples the pre-edge contents, so a read and
   // a write of the same id on the same edge return the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out <= '0;
      end else if (a_re) begin
         a_out <= a_rdata;
      end
   end

   // Port B state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_state <= IDLE;
      end else begin
         b_state <= b_state_next;
      end
   end

   // Port B next-state logic. A request waiting in IDLE is retried every
   // edge until port A stops writing. WAITLOW waits for the requester to
   // drop b_req so one held request cannot be serviced twice.
   always_comb begin
      b_state_next = b_state;
      b_accept     = 1'b0;
      case (b_state)
         IDLE: begin
            if (b_req && !a_we) begin
               b_accept     = 1'b1;
               b_state_next = ACK;
            end
         end
         ACK: begin
            b_state_next = WAITLOW;
         end
         WAITLOW: begin
            if (!b_req) begin
               b_state_next = IDLE;
            end
         end
         default: begin
            b_state_next = IDLE;
         end
      endcase
   end

   // Port B outputs. b_ack is a flop that is high exactly while the FSM sits
   // in ACK. b_rd only changes on an accepted read, so it holds between acks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_ack <= 1'b0;
         b_rd  <= '0;
      end else begin
         b_ack <= (b_state_next == ACK);
         if (b_accept && !b_we) begin
            b_rd <= b_rdata;
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//
// Directed bench for reg_file (NREGS=16, WIDTH=64). Inputs change 1ns after
// each rising edge and outputs are checked at that same point, so every
// check sees the state left by the edge just taken.
// ---------------------------------------------------------------------------
module tb_reg_file;

   localparam int WIDTH = 64;

   logic             clk;
   logic             rst;
   logic [3:0]       a_id;
   logic             a_re;
   logic             a_we;
   logic [WIDTH-1:0] a_wd;
   logic [WIDTH-1:0] a_out;
   logic             b_req;
   logic             b_we;
   logic [3:0]       b_id;
   logic [WIDTH-1:0] b_wd;
   logic             b_ack;
   logic [WIDTH-1:0] b_rd;

   int assertCount;
   int failCount;

   reg_file #(
      .NREGS(16),
      .WIDTH(WIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .a_id  (a_id),
      .a_re  (a_re),
      .a_we  (a_we),
      .a_wd  (a_wd),
      .a_out (a_out),
      .b_req (b_req),
      .b_we  (b_we),
      .b_id  (b_id),
      .b_wd  (b_wd),
      .b_ack (b_ack),
      .b_rd  (b_rd)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1ns past it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed sequence: each step sets inputs, takes an edge and checks.
   initial begin
      assertCount = 0;
      failCount   = 0;
      rst   = 1'b1;
      a_id  = '0;
      a_re  = 1'b0;
      a_we  = 1'b0;
      a_wd  = '0;
      b_req = 1'b0;
      b_we  = 1'b0;
      b_id  = '0;
      b_wd  = '0;

      // Reset values, checked before any clock edge.
      #2;
      checkOutput("rst_a_out", a_out, 64'h0);
      checkOutput("rst_b_ack", {63'h0, b_ack}, 64'h0);
      checkOutput("rst_b_rd", b_rd, 64'h0);
      applyStimulus();
      applyStimulus();
      rst = 1'b0;
      $display("[TB] reset released");

      // Read id 5 after reset, then sweep all 16 ids.
      a_re = 1'b1;
      a_id = 4'd5;
      applyStimulus();
      checkOutput("rd5_after_rst", a_out, 64'h0);
      for (int i = 0; i < 16; i++) begin
         a_id = 4'(i);
         applyStimulus();
         checkOutput($sformatf("sweep_id%0d", i), a_out, 64'h0);
      end

      // Port A write id 3; a_out holds while a_re is low.
      a_re = 1'b0;
      a_we = 1'b1;
      a_id = 4'd3;
      a_wd = 64'h0000_0000_1234_0000;
      applyStimulus();
      checkOutput("hold_during_wr", a_out, 64'h0);
      a_we = 1'b0;
      a_re = 1'b1;
      applyStimulus();
      checkOutput("rd3_after_wr", a_out, 64'h0000_0000_1234_0000);

      // Same-edge read and write of id 3: old value now, new value next.
      a_we = 1'b1;
      a_wd = 64'h0000_0000_0000_00FF;
      applyStimulus();
      checkOutput("rd_before_wr", a_out, 64'h0000_0000_1234_0000);
      a_we = 1'b0;
      applyStimulus();
      checkOutput("rd_new_value", a_out, 64'h0000_0000_0000_00FF);

      // a_re low holds a_out even though a_id points elsewhere.
      a_re = 1'b0;
      a_id = 4'd5;
      applyStimulus();
      checkOutput("a_out_hold", a_out, 64'h0000_0000_0000_00FF);

      // Port B read of id 3 blocked by three cycles of port A writes to id 3.
      b_req = 1'b1;
      b_we  = 1'b0;
      b_id  = 4'd3;
      a_we  = 1'b1;
      a_id  = 4'd3;
      a_wd  = 64'h11;
      applyStimulus();
      checkOutput("blocked_ack_c1", {63'h0, b_ack}, 64'h0);
      a_wd = 64'h22;
      applyStimulus();
      checkOutput("blocked_ack_c2", {63'h0, b_ack}, 64'h0);
      a_wd = 64'h33;
      applyStimulus();
      checkOutput("blocked_ack_c3", {63'h0, b_ack}, 64'h0);
      a_we = 1'b0;
      applyStimulus();
      checkOutput("ack_after_block", {63'h0, b_ack}, 64'h1);
      checkOutput("b_rd_last_a_wr", b_rd, 64'h33);

      // b_req held high for five more cycles: no second ack, b_rd holds.
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput($sformatf("held_req_ack_c%0d", i), {63'h0, b_ack}, 64'h0);
      end
      checkOutput("b_rd_held", b_rd, 64'h33);

      // Drop and reassert: second ack, reading id 5 (still zero).
      b_req = 1'b0;
      applyStimulus();
      checkOutput("ack_low_req_low", {63'h0, b_ack}, 64'h0);
      b_req = 1'b1;
      b_id  = 4'd5;
      applyStimulus();
      checkOutput("second_ack", {63'h0, b_ack}, 64'h1);
      checkOutput("second_b_rd", b_rd, 64'h0);
      b_req = 1'b0;
      applyStimulus();
      applyStimulus();

      // Port B write id 7 with a same-edge port A read of id 7.
      b_req = 1'b1;
      b_we  = 1'b1;
      b_id  = 4'd7;
      b_wd  = 64'hDEAD_BEEF_0000_0001;
      a_re  = 1'b1;
      a_id  = 4'd7;
      applyStimulus();
      checkOutput("b_wr7_ack", {63'h0, b_ack}, 64'h1);
      checkOutput("a_rd7_same_edge", a_out, 64'h0);
      checkOutput("b_rd_kept_on_wr", b_rd, 64'h0);

      // Changing b_wd after acceptance must not disturb the stored value.
      b_req = 1'b0;
      b_wd  = 64'h5555_5555_5555_5555;
      applyStimulus();
      checkOutput("a_rd7_new", a_out, 64'hDEAD_BEEF_0000_0001);
      applyStimulus();
      checkOutput("a_rd7_stable", a_out, 64'hDEAD_BEEF_0000_0001);

      // Port B write id 15, then reset in the middle of the ACK cycle.
      b_req = 1'b1;
      b_we  = 1'b1;
      b_id  = 4'd15;
      b_wd  = 64'h0000_0000_0000_ABCD;
      a_re  = 1'b0;
      applyStimulus();
      checkOutput("b_wr15_ack", {63'h0, b_ack}, 64'h1);
      rst = 1'b1;
      #1;
      checkOutput("mid_ack_rst_ack", {63'h0, b_ack}, 64'h0);
      checkOutput("mid_ack_rst_a_out", a_out, 64'h0);

      // A still-high read request across reset is a new request, accepted
      // on the first edge after release; id 15 reads back as cleared.
      b_we = 1'b0;
      a_re = 1'b1;
      a_id = 4'd15;
      applyStimulus();
      checkOutput("in_rst_ack", {63'h0, b_ack}, 64'h0);
      rst = 1'b0;
      applyStimulus();
      checkOutput("post_rst_ack", {63'h0, b_ack}, 64'h1);
      checkOutput("post_rst_b_rd15", b_rd, 64'h0);
      checkOutput("post_rst_a_rd15", a_out, 64'h0);
      b_req = 1'b0;
      a_id  = 4'd7;
      applyStimulus();
      checkOutput("post_rst_a_rd7", a_out, 64'h0);
      checkOutput("post_rst_ack_drop", {63'h0, b_ack}, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter NREGS, default 16, number of registers (ids 0..NREGS-1).
REQ-002 Parameter WIDTH, default 64, register width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a_id  input  4  executor-port register select.
REQ-006 a_re  input  1  executor read enable.
REQ-007 a_we  input  1  executor write enable.
REQ-008 a_wd  input  WIDTH  executor write data.
REQ-009 a_out  output  WIDTH  executor read data, registered.
REQ-010 b_req  input  1  debug-port request, level, held until b_ack.
REQ-011 b_we  input  1  debug request type: 1 write, 0 read; sampled with b_req.
REQ-012 b_id  input  4  debug register select.
REQ-013 b_wd  input  WIDTH  debug write data.
REQ-014 b_ack  output  1  one-cycle completion pulse.
REQ-015 b_rd  output  WIDTH  debug read data, valid when b_ack=1, held until next ack.

Function
REQ-016 Storage SHALL be NREGS x WIDTH flops; ids >= NREGS SHALL read 0 and ignore writes.
REQ-017 Port A read: at each rising edge with a_re=1, a_out SHALL load regs[a_id] (pre-edge contents); with a_re=0, a_out SHALL hold.
REQ-018 Port A read latency SHALL be exactly one cycle: a_re raised before edge N gives valid a_out after edge N.
REQ-019 Port A write: at each rising edge with a_we=1, regs[a_id] SHALL load a_wd; a_we held for several cycles SHALL rewrite each cycle.
REQ-020 Same-edge a_re and a_we on the same id SHALL be read-before-write: a_out gets old value, new value visible on the following read edge.
REQ-021 Port A SHALL never stall and has absolute priority over port B.
REQ-022 Port B FSM states: IDLE, ACK, WAITLOW.
REQ-023 IDLE -> ACK when b_req=1 and a_we=0 at an edge; at that edge perform access: write regs[b_id]<=b_wd if b_we, else b_rd<=regs[b_id].
REQ-024 IDLE with b_req=1 and a_we=1 SHALL stay IDLE (no access, no ack); service retried every cycle.
REQ-025 ACK: b_ack=1 for exactly one cycle; next edge -> WAITLOW.
REQ-026 WAITLOW -> IDLE on first edge with b_req=0; no new request accepted while in WAITLOW.
REQ-027 b_ack SHALL be registered and 0 in IDLE and WAITLOW.
REQ-028 Port B write and port A read of the same id at the same edge: a_out gets old value.
REQ-029 Port B read of a register written by port A at an earlier edge SHALL return the written value.
REQ-030 b_id, b_we, b_wd SHALL be sampled only at the accepting edge; changes afterwards have no effect.

Reset
REQ-031 rst=1 SHALL immediately clear all registers, a_out, b_rd to 0, b_ack to 0, FSM to IDLE, regardless of clk.
REQ-032 Reset mid-handshake SHALL abort it: no ack issued; after release, a still-high b_req is treated as a new request.
REQ-033 First access SHALL be accepted on the first rising edge after rst falls.

Verification
REQ-034 Reset, a_re=1 a_id=5 -> a_out=0 after next edge; all 16 registers read 0.
REQ-035 a_we=1 a_id=3 a_wd=0x0000_0000_1234_0000, then a_re=1 a_id=3 -> a_out=0x0000_0000_1234_0000 one cycle later; same-edge re+we with a_wd=0xFF -> a_out still 0x1234_0000, next read 0xFF.
REQ-036 b_req=1 b_we=0 b_id=3 with a_we=1 held 3 cycles -> b_ack stays 0 for 3 cycles, pulses once on 4th cycle with b_rd = last A-written value.
REQ-037 b_req held high 5 cycles after ack -> exactly one b_ack; drop and reassert b_req -> second ack.
REQ-038 b write id=7 data=0xDEAD_BEEF_0000_0001, then a_re id=7 -> a_out=0xDEAD_BEEF_0000_0001; b write to id 15 then rst pulse mid-ACK -> id 15 reads 0, b_ack 0.
